// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, FSM state and operator types shared by the keypad calculator
package keypad_pkg;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CONVERT = 2'd2,
        SHOW    = 2'd3
    } calc_state_t;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} calc_op_t;
endpackage

// File: rtl/bcd_dd_seq.sv
// bcd_dd_seq: sequential double-dabble, one add-3 pass plus shift per cycle
module bcd_dd_seq #(
    parameter int BIN_W      = 11,
    parameter int RES_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [BIN_W-1:0]        bin,
    output logic [4*RES_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    done
);
    localparam int BCD_W = 4*RES_DIGITS;
    localparam int CNT_W = $clog2(BIN_W+1);
    logic [BCD_W-1:0] work, adj;
    logic [BIN_W-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             fin;
    for (genvar i = 0; i < RES_DIGITS; i++) begin : g_adj
        assign adj[4*i+:4] = (work[4*i+:4] >= 4'd5) ? work[4*i+:4] + 4'd3 : work[4*i+:4];
    end
    // busy drops after the last shift; fin holds the completed value for one cycle before loading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            sh   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            busy <= 1'b0;
            fin  <= 1'b0;
            done <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            fin  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= fin;
            fin  <= 1'b0;
            if (fin) bcd <= work;
            if (start) begin
                work <= '0;
                sh   <= bin;
                cnt  <= CNT_W'(BIN_W);
                busy <= 1'b1;
            end else if (busy) begin
                {work, sh} <= {adj[BCD_W-2:0], sh, 1'b0};
                cnt        <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/keypad_bcd_calc.sv
// keypad_bcd_calc: keypad add/subtract calculator with signed BCD result output
module keypad_bcd_calc
    import keypad_pkg::*;
#(
    parameter int N_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [4*N_DIGITS-1:0]   entry_bcd,
    output logic [4*N_DIGITS+3:0]   result_bcd,
    output logic                    result_neg,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              state_dbg
);
    localparam int BIN_W      = $clog2(2*10**N_DIGITS);
    localparam int RES_DIGITS = N_DIGITS+1;
    localparam int ENT_W      = 4*N_DIGITS;
    localparam int NDW        = $clog2(N_DIGITS+1);
    localparam int MAXV       = 10**N_DIGITS - 1;
    localparam logic signed [BIN_W:0] SMAX = (BIN_W+1)'(MAXV);
    localparam logic signed [BIN_W:0] SMIN = -SMAX;

    calc_state_t             state, nxt;
    calc_op_t                op;
    logic [ENT_W-1:0]        entry;
    logic [NDW-1:0]          ndig;
    logic [BIN_W-1:0]        acc, mag;
    logic signed [BIN_W:0]   opa, res, last_res, sat;
    logic                    neg_pend, dig, opk, clr, eq, start, finishing, dd_busy, dd_done;
    logic                    entering;

    assign dig       = key_valid && key_code <= 4'd9;
    assign opk       = key_valid && (key_code == KEY_ADD || key_code == KEY_SUB);
    assign clr       = key_valid && key_code == KEY_CLR;
    assign eq        = key_valid && key_code == KEY_EQ;
    assign entering  = state == ENTER_A || state == ENTER_B;
    assign start     = eq && state == ENTER_B;
    assign finishing = state == CONVERT && !dd_busy && !clr;
    assign res       = (op == OP_SUB) ? opa - $signed({1'b0, acc}) : opa + $signed({1'b0, acc});
    assign mag       = res[BIN_W] ? BIN_W'(-res) : res[BIN_W-1:0];
    // chained results are clamped so opA stays within one operand's magnitude
    assign sat       = (last_res > SMAX) ? SMAX : (last_res < SMIN) ? SMIN : last_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTER_A;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ENTER_A: nxt = opk ? ENTER_B : ENTER_A;
            ENTER_B: nxt = eq ? CONVERT : ENTER_B;
            CONVERT: nxt = dd_busy ? CONVERT : SHOW;
            SHOW:    nxt = opk ? ENTER_B : dig ? ENTER_A : SHOW;
        endcase
        if (clr) nxt = ENTER_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry      <= '0;
            ndig       <= '0;
            acc        <= '0;
            opa        <= '0;
            op         <= OP_ADD;
            last_res   <= '0;
            neg_pend   <= 1'b0;
            result_neg <= 1'b0;
        end else if (clr) begin
            entry <= '0;
            ndig  <= '0;
            acc   <= '0;
            opa   <= '0;
            op    <= OP_ADD;
        end else begin
            if (dig && entering && ndig < NDW'(N_DIGITS)) begin
                entry <= ENT_W'({entry, key_code});
                ndig  <= ndig + 1'b1;
                acc   <= acc * BIN_W'(10) + BIN_W'(key_code);
            end
            if (dig && state == SHOW) begin
                entry <= ENT_W'(key_code);
                ndig  <= NDW'(1);
                acc   <= BIN_W'(key_code);
            end
            if (opk && state != CONVERT) op <= (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
            if (opk && (state == ENTER_A || state == SHOW)) begin
                opa   <= (state == SHOW) ? sat : $signed({1'b0, acc});
                entry <= '0;
                ndig  <= '0;
                acc   <= '0;
            end
            if (start) begin
                last_res <= res;
                neg_pend <= res[BIN_W];
            end
            if (finishing) result_neg <= neg_pend;
        end
    end

    bcd_dd_seq #(.BIN_W(BIN_W), .RES_DIGITS(RES_DIGITS)) u_dd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (clr),
        .bin   (mag),
        .bcd   (result_bcd),
        .busy  (dd_busy),
        .done  (dd_done)
    );

    assign entry_bcd = entry;
    assign busy      = dd_busy;
    assign done      = dd_done;
    assign state_dbg = state;
endmodule

// File: tb/tb_keypad_bcd_calc.sv
// tb_keypad_bcd_calc: directed key sequences with hand-computed results for 3- and 5-digit builds
module tb_keypad_bcd_calc;
    logic        clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] entry_a;
    logic [15:0] res_a;
    logic        neg_a, busy_a, done_a;
    logic [1:0]  st_a;
    logic [19:0] entry_b;
    logic [23:0] res_b;
    logic        neg_b, busy_b, done_b;
    logic [1:0]  st_b;
    int          checks = 0, errors = 0;

    keypad_bcd_calc #(.N_DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .entry_bcd(entry_a), .result_bcd(res_a), .result_neg(neg_a),
        .busy(busy_a), .done(done_a), .state_dbg(st_a)
    );
    keypad_bcd_calc #(.N_DIGITS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .entry_bcd(entry_b), .result_bcd(res_b), .result_neg(neg_b),
        .busy(busy_b), .done(done_b), .state_dbg(st_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            @(negedge clk);
            key_valid = 1'b1;
            key_code  = (c >= 8'h41) ? 4'(c - 8'h37) : 4'(c - 8'h30);
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input bit sel, input int exp_cyc, input string tag);
        int c;
        c = 0;
        while (!(sel ? done_b : done_a) && c < 60) begin
            @(negedge clk);
            c++;
        end
        check(tag, c, exp_cyc);
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (done_a) seen++;
            @(negedge clk);
        end
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_state", st_a, 0);
        check("rst_entry", entry_a, 0);
        check("rst_result", res_a, 0);
        check("rst_flags", {neg_a, busy_a, done_a}, 0);
        rst_n = 1'b1;

        keys("123");
        check("entry_123", entry_a, 32'h123);
        keys("A");
        check("op_state", st_a, 1);
        check("op_entry_clr", entry_a, 0);
        keys("456E");
        check("eq_busy", {busy_a, done_a}, 2'b10);
        check("eq_state", st_a, 2);
        wait_done(0, 12, "lat_579");
        check("res_579", res_a, 32'h0579);
        check("neg_579", neg_a, 0);
        check("show_state", {st_a, busy_a}, {2'd3, 1'b0});
        @(negedge clk);
        check("done_pulse", done_a, 0);

        keys("C5B12E");
        wait_done(0, 12, "lat_m7");
        check("res_m7", {neg_a, res_a}, {1'b1, 16'h0007});
        keys("A3E");
        wait_done(0, 12, "lat_m4");
        check("res_m4", {neg_a, res_a}, {1'b1, 16'h0004});

        keys("C9999");
        check("entry_full", entry_a, 32'h999);
        keys("A999E");
        wait_done(0, 12, "lat_1998");
        check("res_1998", {neg_a, res_a}, {1'b0, 16'h1998});

        keys("7");
        check("show_digit", {st_a, entry_a}, {2'd0, 12'h007});
        keys("A3EC");
        count_done(20, seen);
        check("abort_done", seen, 0);
        check("abort_state", {st_a, busy_a}, 0);
        check("abort_hold", {neg_a, res_a}, {1'b0, 16'h1998});
        keys("7A3E");
        repeat (10) @(negedge clk);
        keys("C");
        count_done(20, seen);
        check("lastcyc_done", seen, 0);
        check("lastcyc_hold", {st_a, res_a}, {2'd0, 16'h1998});

        keys("4FD");
        check("ignore_fd", {st_a, entry_a}, {2'd0, 12'h004});
        keys("E");
        check("eq_in_a", st_a, 0);
        keys("A2B");
        check("op_replace", {st_a, entry_a}, {2'd1, 12'h002});
        keys("E");
        wait_done(0, 12, "lat_2");
        check("res_2", {neg_a, res_a}, {1'b0, 16'h0002});

        keys("C1A1E");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outs", {st_a, entry_a, res_a, neg_a, busy_a, done_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        keys("99999");
        check("b_entry", entry_b, 32'h99999);
        keys("A99999E");
        check("b_busy", busy_b, 1);
        wait_done(1, 19, "b_lat");
        check("b_res", {neg_b, res_b}, {1'b0, 24'h199998});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_bcd_calc.md
# keypad_bcd_calc

Parametrised keypad calculator core: the successor of the fixed three-digit keypad adder. It accepts operands of up to N_DIGITS decimal digits from the keypad scanner, with a selectable operator (add or subtract) and clear and equals keys. Arithmetic is binary. A multi-cycle sequential double-dabble converter produces a signed BCD result for the 7-segment display driver. Key input is a validated one-cycle strobe from the debounced scanner, so no change detection happens in this block.

## Interface
Parameters:
- N_DIGITS, 3: maximum digits per operand; legal range 1..6.
- Derived localparam BIN_W = $clog2(2*10**N_DIGITS): binary datapath width.
- Derived localparam RES_DIGITS = N_DIGITS+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock domain, asynchronous assert, active-low.
- key_valid  in  1  one-cycle strobe; key_code is valid when high.
- key_code  in  4  key code:
  - 0x0–0x9: digit.
  - 0xA: add.
  - 0xB: subtract.
  - 0xC: clear.
  - 0xE: equals.
  - 0xD and 0xF: ignored.
- entry_bcd  out  4*N_DIGITS  digits of the operand being typed; LSD in bits [3:0].
- result_bcd  out  4*RES_DIGITS  magnitude of the last result in BCD.
- result_neg  out  1  the last result was negative.
- busy  out  1  high while converting.
- done  out  1  one-cycle pulse when result_bcd and result_neg update.
- state_dbg  out  2  current FSM state encoding, for the LED debug header.

## Operation
- States: ENTER_A=0, ENTER_B=1, CONVERT=2, SHOW=3.
- Only cycles with key_valid=1 and a non-ignored code act.
- Digit key in ENTER_A or ENTER_B:
  - If the entry already holds N_DIGITS digits, the key is ignored (no wrap, no overwrite).
  - Otherwise entry_bcd shifts left one digit with the new digit in the LSD.
  - The binary accumulator updates as acc = acc*10 + d.
- Operator key (0xA or 0xB):
  - In ENTER_A: latch acc into opA, latch the op, clear entry and acc, go to ENTER_B. Empty entry means opA=0.
  - In ENTER_B: replaces the latched op only; entry is untouched.
  - In SHOW: chains. opA becomes the signed result, the op is latched, go to ENTER_B.
- Equals key (0xE):
  - In ENTER_B: compute res = opA ± acc as a signed BIT W+1 value; result_neg = res<0; mag = |res|. Load mag into the converter and go to CONVERT.
  - In ENTER_A or SHOW: ignored.
- Digit key in SHOW: clears the entry, starts a new operand A with that digit, goes to ENTER_A.
- Clear key (0xC), in any state, including mid-CONVERT:
  - Entry, acc, opA and op go to 0; state goes to ENTER_A.
  - Any conversion is aborted; result_bcd keeps its last completed value; no done pulse.
- Any other key during CONVERT is ignored; it is not buffered.
- Chained negative opA: the magnitude is bounded by 10^N_DIGITS-1 per operand. Chained results are saturated to ±(10^N_DIGITS-1) before use as opA.

## Timing
- Reset values:
  - state ENTER_A.
  - entry_bcd, result_bcd, opA, acc: 0.
  - result_neg, busy, done: 0.
  - state_dbg: 0.
- Key response: a key sampled at edge k updates entry_bcd and state at edge k.
- Equals: accepted at edge k.
  - busy=1 from cycle k+1 through k+BIN_W.
  - The converter shifts one bit per cycle.
  - At edge k+BIN_W+1, result_bcd and result_neg load and done=1 for exactly that cycle; busy=0 and state=SHOW.
- Clear coincident with the final conversion cycle: clear wins; no load, no done.
- Every output is registered.

## Structure
- Shared package keypad_pkg holds:
  - the key-code localparams (KEY_ADD, KEY_SUB, KEY_CLR, KEY_EQ);
  - the state typedef calc_state_t;
  - the op typedef calc_op_t {OP_ADD, OP_SUB}.
- Sub-module bcd_dd_seq, parameters BIN_W and RES_DIGITS:
  - inputs start, bin, abort; outputs bcd, busy, done.
  - one add-3 pass plus shift per cycle.
  - its done directly produces the parent's done.
- The parent holds the FSM, accumulators, operator latch and saturation.

## Test plan
- N_DIGITS=3: keys 1,2,3,A,4,5,6,E → done at BIN_W+1 cycles after E; result_bcd=0x0579; result_neg=0.
- Keys 5,B,1,2,E → result_bcd=0x0007, result_neg=1. Then keys A,3,E chain to −4: result_bcd=0x0004, result_neg=1.
- Keys 9,9,9,9,A,9,9,9,E: the fourth 9 is ignored; result_bcd=0x1998.
- Keys 7,A,3,E, then C two cycles later → no done pulse; state=ENTER_A; result_bcd holds its previous value.
- rst_n low mid-CONVERT → all outputs 0 immediately (asynchronous); 0xF and 0xD key strobes cause no change.
- N_DIGITS=5: keys 99999 + 99999 → result_bcd=0x199998; BIN_W=18; done 19 cycles after E.
